// File: rtl/mem_instr_pipe_if.sv
// Fetch, response and program-load signals shared by the instruction memory and its neighbours.
// The master side is the PC/fetch stage plus loader; the slave side is mem_instr_pipe.
interface mem_instr_pipe_if #(
    parameter int bus_length = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [bus_length-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_instr;
    logic [bus_length-1:0] rsp_addr;
    logic                  rsp_fault;
    logic                  rsp_parity_err;
    logic                  load_en;
    logic [bus_length-1:0] load_addr;
    logic [31:0]           load_data;

    modport master (
        output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, rsp_parity_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault, rsp_parity_err
    );
endinterface

// File: rtl/mem_instr_pipe.sv
// Word-organised big-endian instruction memory with registered fetch, 2-entry response buffer,
// program-load port and fault reporting. Optional stored-word parity under MEM_INSTR_PARITY_EN.
module mem_instr_pipe #(
    parameter int          bus_length  = 64,
    parameter int          depth_words = 64,
    parameter logic [31:0] nop_instr   = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_instr_pipe_if.slave bus
);
    localparam int addr_w = (depth_words > 1) ? $clog2(depth_words) : 1;
    // One extra bit keeps the byte-size constant from wrapping at full bus width.
    localparam logic [bus_length:0] mem_bytes = (bus_length + 1)'(4 * depth_words);

    typedef struct packed {
        logic [31:0]           instr;
        logic [bus_length-1:0] addr;
        logic                  fault;
        logic                  parity_err;
    } rsp_entry_t;

    logic [31:0] mem [depth_words];
`ifdef MEM_INSTR_PARITY_EN
    logic        mem_par [depth_words];
`endif

    rsp_entry_t  rsp_buf [2];
    rsp_entry_t  head;
    rsp_entry_t  new_entry;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;
    logic        req_fault;
    logic        load_in_range;
    logic [addr_w-1:0] req_idx;
    logic [addr_w-1:0] load_idx;
    logic [31:0] rd_word;
    logic        rd_par_err;

    always_comb begin
        req_idx       = bus.req_addr[addr_w+1:2];
        load_idx      = bus.load_addr[addr_w+1:2];
        req_fault     = (bus.req_addr[1:0] != 2'b00) || ({1'b0, bus.req_addr} >= mem_bytes);
        load_in_range = {1'b0, bus.load_addr} < mem_bytes;
        rd_word       = mem[req_idx];
`ifdef MEM_INSTR_PARITY_EN
        rd_par_err    = mem_par[req_idx] != (^rd_word);
`else
        rd_par_err    = 1'b0;
`endif
        new_entry.addr = bus.req_addr;
        if (req_fault) begin
            new_entry.instr      = nop_instr;
            new_entry.fault      = 1'b1;
            new_entry.parity_err = 1'b0;
        end else begin
            new_entry.instr      = rd_word;
            new_entry.fault      = 1'b0;
            new_entry.parity_err = rd_par_err;
        end
    end

    // Handshake: a full buffer still takes a request when the head leaves on the same edge.
    always_comb begin
        head               = rsp_buf[rd_ptr];
        bus.req_ready      = (count < 2'd2) || ((count == 2'd2) && bus.rsp_ready);
        bus.rsp_valid      = (count != 2'd0);
        push               = bus.req_valid && bus.req_ready;
        pop                = bus.rsp_valid && bus.rsp_ready;
        bus.rsp_instr      = 32'h0;
        bus.rsp_addr       = '0;
        bus.rsp_fault      = 1'b0;
        bus.rsp_parity_err = 1'b0;
        if (bus.rsp_valid) begin
            bus.rsp_instr      = head.instr;
            bus.rsp_addr       = head.addr;
            bus.rsp_fault      = head.fault;
            bus.rsp_parity_err = head.parity_err;
        end
    end

    // Memory array is never reset; non-blocking write gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (bus.load_en && load_in_range) begin
            mem[load_idx] <= bus.load_data;
`ifdef MEM_INSTR_PARITY_EN
            mem_par[load_idx] <= ^bus.load_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_buf[0] <= '0;
            rsp_buf[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                rsp_buf[wr_ptr] <= new_entry;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_instr_pipe.sv
// Self-checking bench for mem_instr_pipe: directed steps then random traffic against a queue model.
// Build with MEM_INSTR_PARITY_EN to exercise the stored-parity error path.
module tb_mem_instr_pipe;
    localparam int          bus_length  = 64;
    localparam int          depth_words = 64;
    localparam logic [31:0] nop_instr   = 32'h0000_0013;
    localparam logic [63:0] mem_bytes   = 64'(4 * depth_words);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_instr_pipe_if #(.bus_length(bus_length)) bus ();

    mem_instr_pipe #(
        .bus_length (bus_length),
        .depth_words(depth_words),
        .nop_instr  (nop_instr)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] addr;
        logic        fault;
        logic        par_err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem  [depth_words];
    logic        ref_flip [depth_words];
    int          n_compared   = 0;
    int          n_mismatched = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: what the response for a fetch of byte address a must carry.
    function automatic exp_t modelFetch(input logic [63:0] a);
        exp_t e;
        e.addr = a;
        if ((a[1:0] != 2'b00) || (a >= mem_bytes)) begin
            e.instr   = nop_instr;
            e.fault   = 1'b1;
            e.par_err = 1'b0;
        end else begin
            e.instr   = ref_mem[int'(a >> 2)];
            e.fault   = 1'b0;
            e.par_err = ref_flip[int'(a >> 2)];
        end
        return e;
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic applyStimulus(input logic rv, input logic [63:0] ra, input logic rr,
                                 input logic le, input logic [63:0] la, input logic [31:0] ld);
        logic exp_ready;
        logic acc;
        logic pop;
        exp_t e;
        @(negedge clk);
        bus.req_valid = rv;
        bus.req_addr  = ra;
        bus.rsp_ready = rr;
        bus.load_en   = le;
        bus.load_addr = la;
        bus.load_data = ld;
        #1;
        exp_ready = (exp_q.size() < 2) || rr;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            checkOutput("rsp_instr", 64'(bus.rsp_instr), 64'(exp_q[0].instr));
            checkOutput("rsp_addr", bus.rsp_addr, exp_q[0].addr);
            checkOutput("rsp_fault", 64'(bus.rsp_fault), 64'(exp_q[0].fault));
            checkOutput("rsp_parity_err", 64'(bus.rsp_parity_err), 64'(exp_q[0].par_err));
        end
        acc = rv && exp_ready;
        pop = (exp_q.size() != 0) && rr;
        e   = modelFetch(ra);
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
        if (le && (la < mem_bytes)) begin
            ref_mem[int'(la >> 2)]  = ld;
            ref_flip[int'(la >> 2)] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'h0);
        checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'h1);
        checkOutput({tag, "_rsp_instr"}, 64'(bus.rsp_instr), 64'h0);
        checkOutput({tag, "_rsp_addr"}, bus.rsp_addr, 64'h0);
        checkOutput({tag, "_rsp_fault"}, 64'(bus.rsp_fault), 64'h0);
        checkOutput({tag, "_rsp_parity_err"}, 64'(bus.rsp_parity_err), 64'h0);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] la;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        for (int i = 0; i < depth_words; i++) ref_flip[i] = 1'b0;

        // Power-up reset
        #2;
        checkResetOutputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Program every word so later fetches have a defined expectation
        for (int i = 0; i < depth_words; i++)
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'(4 * i), (i == 2) ? 32'hAAAA_AAAA : $urandom);

        $display("[TB] test 1: back-to-back fetch");
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h0, 32'h0020_81B3);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h4, 32'h4020_8233);
        applyStimulus(1'b1, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h4, 1'b1, 1'b0, 64'h0, 32'h0);
        idle(2);

        $display("[TB] test 2: backpressure");
        applyStimulus(1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h14, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h18, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h18, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h18, 1'b1, 1'b0, 64'h0, 32'h0);
        idle(4);

        $display("[TB] test 3: faults");
        applyStimulus(1'b1, 64'h2, 1'b1, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h100, 1'b1, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h8000_0000_0000_0008, 1'b1, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h103, 1'b1, 1'b0, 64'h0, 32'h0);
        idle(2);

        $display("[TB] test 4: load/fetch collision");
        applyStimulus(1'b1, 64'h8, 1'b1, 1'b1, 64'h8, 32'h1234_5678);
        applyStimulus(1'b1, 64'h8, 1'b1, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h108, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 64'h8, 1'b1, 1'b0, 64'h0, 32'h0);
        idle(2);

        $display("[TB] test 5: reset with buffered responses");
        applyStimulus(1'b1, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h4, 1'b0, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.load_en   = 1'b0;
        rst_n         = 1'b0;
        #1;
        checkResetOutputs("midrst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        $display("[TB] test 6: parity");
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'hC, 32'h0000_0001);
`ifdef MEM_INSTR_PARITY_EN
        @(negedge clk);
        dut.mem_par[3] = ~dut.mem_par[3];
        ref_flip[3]    = 1'b1;
`endif
        applyStimulus(1'b1, 64'hC, 1'b1, 1'b0, 64'h0, 32'h0);
        applyStimulus(1'b1, 64'h2, 1'b1, 1'b0, 64'h0, 32'h0);
        idle(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       ra = {56'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                1:       ra = mem_bytes + 64'(4 * $urandom_range(0, 15));
                2:       ra = {1'b1, 31'($urandom), 30'($urandom), 2'b00};
                default: ra = 64'(4 * $urandom_range(0, depth_words - 1));
            endcase
            la = 64'($urandom_range(0, 32'h13F));
            applyStimulus($urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 4) == 0, la, $urandom);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/mem_instr_pipe.md
Name: mem_instr_pipe

Overview:
Parametrised successor to the combinational instruction ROM. It is a word-organised instruction memory with big-endian byte addressing: the byte at the lowest address is instr[31:24]. It adds a valid/ready fetch handshake, a registered read path, a 2-entry response buffer, a program-load write port, and fault reporting for misaligned or out-of-range fetches. It sits between the PC/fetch stage and the decoder.

Parameters:
bus_length, 64, width of fetch and load byte addresses.
depth_words, 64, number of 32-bit words stored (byte range 0 .. 4*depth_words-1).
nop_instr, 32'h0000_0013, instruction returned on a faulted fetch (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  fetch request valid.
req_ready  out  1  block can accept a request this cycle.
req_addr  in  bus_length  fetch byte address.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts response.
rsp_instr  out  32  fetched instruction.
rsp_addr  out  bus_length  address the response belongs to.
rsp_fault  out  1  misaligned or out-of-range fetch.
rsp_parity_err  out  1  stored-word parity mismatch; tied 0 without MEM_INSTR_PARITY_EN.
load_en  in  1  write one word into memory.
load_addr  in  bus_length  load byte address; bits [1:0] ignored.
load_data  in  32  word to write, big-endian byte order.

Behaviour:
- Reset is asynchronous on rst_n low. Values while in reset: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_fault=0, rsp_parity_err=0, response buffer empty, req_ready=1. Memory contents are not reset.
- Request acceptance: a request is accepted on a rising edge where req_valid && req_ready.
- req_ready = (buffer occupancy < 2) || (occupancy == 2 && rsp_ready). This allows full throughput of one fetch per cycle.
- Latency: a request accepted at edge N appears in the buffer after edge N and is visible at the head no earlier than the cycle after edge N. It appears on rsp_* in that cycle if the buffer was empty or emptied at edge N.
- Response pop: the head entry pops on an edge where rsp_valid && rsp_ready. Responses are strictly in order.
- Response stability: rsp_* are stable while rsp_valid && !rsp_ready.
- Simultaneous events: push and pop on the same edge leave occupancy unchanged. At occupancy 2, a push is accepted only together with a pop.
- Fault when req_addr[1:0] != 0: rsp_fault=1, rsp_instr=nop_instr, memory is not read, rsp_addr = req_addr.
- Fault when req_addr >= 4*depth_words: same response as the misaligned case. If both conditions hold, report a single fault.
- Address arithmetic: word index = req_addr[bus_length-1:2]. The full-width range compare prevents aliasing. There is no wrap-around.
- Load port: on an edge with load_en, mem[load_addr>>2] <= load_data. An out-of-range load is silently dropped. Loads are independent of the fetch handshake.
- Load/fetch collision: a load and a fetch to the same word on the same edge is read-before-write; the fetch returns the old word.
- Reset mid-operation: in-flight and buffered responses are discarded. After rst_n rises, the first response comes only from a new request.

Optional Feature:
MEM_INSTR_PARITY_EN:
- Defined: each word stores an extra even-parity bit computed from load_data at write time. On a non-faulted fetch, rsp_parity_err=1 if the stored bit != ^word. rsp_instr still carries the stored word, and rsp_parity_err is buffered alongside it. A word never loaded since power-up has undefined parity.
- Undefined: no parity storage, and rsp_parity_err is constant 0.

Test Plan:
1. Reset, then load 32'h0020_81B3 at 0x0 and 32'h4020_8233 at 0x4. Fetch 0x0 then 0x4 back-to-back with rsp_ready=1 -> req_ready stays 1. rsp_instr = 0020_81B3 then 4020_8233, each one cycle after acceptance, with rsp_addr 0x0/0x4 and rsp_fault=0.
2. Hold rsp_ready=0 and issue 3 fetches -> req_ready drops after 2 acceptances and rsp_* hold the first response. Raise rsp_ready -> responses drain in order and the third request is accepted on the first pop.
3. Fetch 0x2 -> rsp_fault=1, rsp_instr=0000_0013. Fetch 0x100 with depth_words=64 -> rsp_fault=1, rsp_instr=0000_0013.
4. With word 0x8 = 0xAAAA_AAAA, load 0x1234_5678 at 0x8 and fetch 0x8 on the same edge -> response is AAAA_AAAA. The next fetch of 0x8 returns 1234_5678.
5. With 2 responses buffered, assert rst_n=0 for one cycle -> rsp_valid=0 immediately and req_ready=1. No stale response appears after release.
6. With MEM_INSTR_PARITY_EN defined, load 0x0000_0001 at 0xC, then force the stored parity bit to flip and fetch 0xC -> rsp_parity_err=1, rsp_instr=0000_0001. Without the macro -> rsp_parity_err=0.
